// File: rtl/br_resolve_unit_pkg.sv
// Shared bus layouts, counter encodings and FSM state codes for the EXE branch resolver.
package br_resolve_unit_pkg;

  localparam int BPU_TO_DS_BUS_WD = 36;
  localparam int BRESULT_BUS_WD   = 69;

  // 2-bit predictor counter encodings
  localparam logic [1:0] W_TAKEN  = 2'b00;
  localparam logic [1:0] S_TAKEN  = 2'b01;
  localparam logic [1:0] WN_TAKEN = 2'b10;
  localparam logic [1:0] SN_TAKEN = 2'b11;

  // Field offsets, kept for consumers that still slice the flat buses
  localparam int PRED_TAKEN_BIT = 35;
  localparam int PRED_COUNT_LSB = 33;
  localparam int PRED_VALID_BIT = 32;
  localparam int BRES_PC_LSB    = 37;
  localparam int BRES_CNT_LSB   = 35;
  localparam int BRES_ISBR_BIT  = 34;
  localparam int BRES_STALL_BIT = 33;
  localparam int BRES_TAKEN_BIT = 32;

  typedef struct packed {
    logic        taken;
    logic [1:0]  count;
    logic        valid;
    logic [31:0] ret_addr;
  } pred_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  old_count;
    logic        is_branch;
    logic        br_stall;
    logic        taken;
    logic [31:0] target;
  } bresult_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SLOT = 2'd1;
  localparam logic [1:0] ST_REDIRECT  = 2'd2;

  // Sequential fall-through past the delay slot
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/br_mispredict_cmp.sv
// Combinational compare of the carried prediction against the real outcome; no state, no backpressure.
module br_mispredict_cmp
  import br_resolve_unit_pkg::*;
#(
  parameter logic [1:0] NEW_CNT = WN_TAKEN
) (
  input  logic [31:0] ex_pc,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  pred_bus_t   pred,
  output logic [31:0] act_next,
  output logic        mispredict,
  output logic [1:0]  old_cnt
);

  logic [31:0] pred_next;

  always_comb begin
    pred_next  = (pred.valid && pred.taken) ? pred.ret_addr : seq_pc(ex_pc);
    act_next   = ex_br_taken ? ex_br_target : seq_pc(ex_pc);
    // Also fires for non-branches: a stale taken hit must be undone
    mispredict = (pred_next != act_next);
    old_cnt    = pred.valid ? pred.count : NEW_CNT;
  end

endmodule

// File: rtl/br_resolve_unit.sv
// EXE-stage branch resolver: 1-cycle BResult update pulse, delay-slot aware redirect FSM, saturating stats.
// Redirect is held until fetch accepts it (fs_allowin); ex_flush overrides everything.
module br_resolve_unit
  import br_resolve_unit_pkg::*;
#(
  parameter int         CNT_WIDTH = 32,
  parameter logic [1:0] NEW_CNT   = WN_TAKEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ex_go,
  input  logic [31:0]                 ex_pc,
  input  logic                        ex_is_branch,
  input  logic                        ex_br_taken,
  input  logic [31:0]                 ex_br_target,
  input  logic [BPU_TO_DS_BUS_WD-1:0] ex_pred_bus,
  input  logic                        ds_valid,
  input  logic                        fs_allowin,
  input  logic                        ex_flush,
  output logic [BRESULT_BUS_WD-1:0]   BResult,
  output logic                        redirect_valid,
  output logic [31:0]                 redirect_pc,
  output logic                        bru_busy,
  output logic [CNT_WIDTH-1:0]        br_cnt,
  output logic [CNT_WIDTH-1:0]        mis_cnt
);

  pred_bus_t   pred;
  logic [31:0] act_next;
  logic        mispredict;
  logic [1:0]  old_cnt;

  assign pred = pred_bus_t'(ex_pred_bus);

  br_mispredict_cmp #(
    .NEW_CNT (NEW_CNT)
  ) u_cmp (
    .ex_pc        (ex_pc),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .pred         (pred),
    .act_next     (act_next),
    .mispredict   (mispredict),
    .old_cnt      (old_cnt)
  );

  logic [1:0]           state_q,   state_d;
  logic [31:0]          fix_pc_q,  fix_pc_d;
  bresult_t             bresult_q, bresult_d;
  logic [CNT_WIDTH-1:0] br_cnt_q,  br_cnt_d;
  logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;
  logic                 resolve;

  // Anything retiring while a redirect is pending is wrong-path
  assign resolve = ex_go && (state_q == ST_IDLE) && !ex_flush;

  always_comb begin
    bresult_d = '0;
    if (resolve && ex_is_branch) begin
      bresult_d.pc        = ex_pc;
      bresult_d.old_count = old_cnt;
      bresult_d.is_branch = 1'b1;
      bresult_d.br_stall  = 1'b0;
      bresult_d.taken     = ex_br_taken;
      bresult_d.target    = ex_br_target;
    end
  end

  always_comb begin
    state_d  = state_q;
    fix_pc_d = fix_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (resolve && mispredict) begin
          fix_pc_d = act_next;
          state_d  = ds_valid ? ST_REDIRECT : ST_WAIT_SLOT;
        end
      end
      ST_WAIT_SLOT: begin
        if (ds_valid) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (fs_allowin) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ex_flush) state_d = ST_IDLE;
  end

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (resolve && ex_is_branch && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
    if (resolve && mispredict && (mis_cnt_q != '1))
      mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fix_pc_q  <= '0;
      bresult_q <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fix_pc_q  <= fix_pc_d;
      bresult_q <= bresult_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign BResult        = bresult_q;
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = fix_pc_q;
  assign bru_busy       = (state_q != ST_IDLE);
  assign br_cnt         = br_cnt_q;
  assign mis_cnt        = mis_cnt_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench: shared stimulus drives a 32-bit-counter instance and a 4-bit-counter instance for saturation.
module tb_br_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_go;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic [35:0] ex_pred_bus;
  logic        ds_valid;
  logic        fs_allowin;
  logic        ex_flush;

  logic [68:0] BResult;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bru_busy;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  logic [68:0] s_BResult;
  logic        s_redirect_valid;
  logic [31:0] s_redirect_pc;
  logic        s_bru_busy;
  logic [3:0]  s_br_cnt;
  logic [3:0]  s_mis_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  br_resolve_unit dut (
    .clk(clk), .reset(reset), .ex_go(ex_go), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .ex_pred_bus(ex_pred_bus),
    .ds_valid(ds_valid), .fs_allowin(fs_allowin), .ex_flush(ex_flush),
    .BResult(BResult), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bru_busy(bru_busy), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  br_resolve_unit #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset), .ex_go(ex_go), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .ex_pred_bus(ex_pred_bus),
    .ds_valid(ds_valid), .fs_allowin(fs_allowin), .ex_flush(ex_flush),
    .BResult(s_BResult), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .bru_busy(s_bru_busy), .br_cnt(s_br_cnt), .mis_cnt(s_mis_cnt)
  );

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [68:0] bres(input logic [31:0] pc, input logic [1:0] cnt,
                                       input logic tk, input logic [31:0] tgt);
    return {pc, cnt, 1'b1, 1'b0, tk, tgt};
  endfunction

  function automatic logic [35:0] pbus(input logic tk, input logic [1:0] cnt,
                                       input logic vld, input logic [31:0] addr);
    return {tk, cnt, vld, addr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_go();
    ex_go = 1'b0; ex_is_branch = 1'b0; ex_br_taken = 1'b0;
    ex_br_target = 32'h0; ex_pred_bus = '0; ex_flush = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic isbr, input logic tk,
                       input logic [31:0] tgt, input logic [35:0] pb);
    ex_go = 1'b1; ex_pc = pc; ex_is_branch = isbr; ex_br_taken = tk;
    ex_br_target = tgt; ex_pred_bus = pb;
  endtask

  task automatic check_redir(input string tag, input logic rv, input logic [31:0] pc, input logic busy);
    check({tag, ".rv"},   69'(redirect_valid), 69'(rv));
    check({tag, ".pc"},   69'(redirect_pc),    69'(pc));
    check({tag, ".busy"}, 69'(bru_busy),       69'(busy));
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] br, input logic [31:0] mis);
    check({tag, ".br_cnt"},  69'(br_cnt),  69'(br));
    check({tag, ".mis_cnt"}, 69'(mis_cnt), 69'(mis));
  endtask

  initial begin
    reset = 1'b1; ex_pc = 32'h0; ds_valid = 1'b0; fs_allowin = 1'b0;
    clear_go();
    step(); step();
    check("rst.bresult", BResult, '0);
    check_redir("rst", 1'b0, 32'h0, 1'b0);
    check_cnt("rst", 32'd0, 32'd0);
    reset = 1'b0;

    // 1: correctly predicted taken branch
    ds_valid = 1'b1; fs_allowin = 1'b1;
    drive(32'hBFC0_0010, 1'b1, 1'b1, 32'hBFC0_0100, pbus(1'b1, 2'b01, 1'b1, 32'hBFC0_0100));
    step();
    check("t1.bresult", BResult, bres(32'hBFC0_0010, 2'b01, 1'b1, 32'hBFC0_0100));
    check_redir("t1", 1'b0, 32'h0, 1'b0);
    check_cnt("t1", 32'd1, 32'd0);
    clear_go();
    step();
    check("t1.pulse", BResult, '0);

    // 2: invalid prediction, taken; fetch stalls the redirect
    fs_allowin = 1'b0;
    drive(32'hBFC0_0040, 1'b1, 1'b1, 32'hBFC0_0200, '0);
    step();
    check("t2.bresult", BResult, bres(32'hBFC0_0040, 2'b10, 1'b1, 32'hBFC0_0200));
    check_redir("t2.c1", 1'b1, 32'hBFC0_0200, 1'b1);
    check_cnt("t2", 32'd2, 32'd1);
    drive(32'hBFC0_0048, 1'b1, 1'b1, 32'h1234_5678, '0);
    step();
    check("t2.wrongpath_bres", BResult, '0);
    check_cnt("t2.wrongpath", 32'd2, 32'd1);
    check_redir("t2.c2", 1'b1, 32'hBFC0_0200, 1'b1);
    clear_go();
    step();
    check_redir("t2.c3", 1'b1, 32'hBFC0_0200, 1'b1);
    fs_allowin = 1'b1;
    step();
    check_redir("t2.done", 1'b0, 32'hBFC0_0200, 1'b0);

    // 3: mispredict before the delay slot reaches DS
    ds_valid = 1'b0;
    drive(32'hBFC0_0300, 1'b1, 1'b0, 32'hBFC0_0400, pbus(1'b1, 2'b00, 1'b1, 32'hBFC0_0400));
    step();
    check("t3.bresult", BResult, bres(32'hBFC0_0300, 2'b00, 1'b0, 32'hBFC0_0400));
    check_redir("t3.w1", 1'b0, 32'hBFC0_0308, 1'b1);
    check_cnt("t3", 32'd3, 32'd2);
    clear_go();
    step();
    check_redir("t3.w2", 1'b0, 32'hBFC0_0308, 1'b1);
    ds_valid = 1'b1;
    step();
    check_redir("t3.redir", 1'b1, 32'hBFC0_0308, 1'b1);
    step();
    check_redir("t3.done", 1'b0, 32'hBFC0_0308, 1'b0);

    // 4: predicted taken, actually not taken at top of address space
    fs_allowin = 1'b0;
    drive(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h8000_0000, pbus(1'b1, 2'b01, 1'b1, 32'h8000_0000));
    step();
    check("t4.bresult", BResult, bres(32'hFFFF_FFFC, 2'b01, 1'b0, 32'h8000_0000));
    check_redir("t4", 1'b1, 32'h0000_0004, 1'b1);
    check_cnt("t4", 32'd4, 32'd3);
    clear_go();
    fs_allowin = 1'b1;
    step();
    check_redir("t4.done", 1'b0, 32'h0000_0004, 1'b0);

    // False taken hit on a non-branch
    drive(32'h0000_1000, 1'b0, 1'b0, 32'h0, pbus(1'b1, 2'b11, 1'b1, 32'h0000_2000));
    step();
    check("nb.bresult", BResult, '0);
    check_redir("nb", 1'b1, 32'h0000_1008, 1'b1);
    check_cnt("nb", 32'd4, 32'd4);
    clear_go();
    step();
    check_redir("nb.done", 1'b0, 32'h0000_1008, 1'b0);

    // 5a: flush alongside a mispredicting retire
    drive(32'h0000_2000, 1'b1, 1'b1, 32'h0000_3000, '0);
    ex_flush = 1'b1;
    step();
    check("t5a.bresult", BResult, '0);
    check_redir("t5a", 1'b0, 32'h0000_1008, 1'b0);
    check_cnt("t5a", 32'd4, 32'd4);
    clear_go();

    // 5b: flush while in REDIRECT
    fs_allowin = 1'b0;
    drive(32'h0000_2000, 1'b1, 1'b1, 32'h0000_3000, '0);
    step();
    check_redir("t5b.pre", 1'b1, 32'h0000_3000, 1'b1);
    clear_go();
    ex_flush = 1'b1;
    step();
    check_redir("t5b", 1'b0, 32'h0000_3000, 1'b0);
    check_cnt("t5b", 32'd5, 32'd5);
    ex_flush = 1'b0;

    // 5c: flush while in WAIT_SLOT beats ds_valid arriving
    ds_valid = 1'b0;
    drive(32'h0000_4000, 1'b1, 1'b1, 32'h0000_5000, '0);
    step();
    check_redir("t5c.pre", 1'b0, 32'h0000_5000, 1'b1);
    clear_go();
    ds_valid = 1'b1; ex_flush = 1'b1;
    step();
    check_redir("t5c", 1'b0, 32'h0000_5000, 1'b0);
    ex_flush = 1'b0;

    // Reset while busy
    ds_valid = 1'b0;
    drive(32'h0000_6000, 1'b1, 1'b1, 32'h0000_7000, '0);
    step();
    check_redir("rb.pre", 1'b0, 32'h0000_7000, 1'b1);
    clear_go();
    reset = 1'b1;
    step();
    check_redir("rb", 1'b0, 32'h0, 1'b0);
    check_cnt("rb", 32'd0, 32'd0);
    reset = 1'b0;

    // 6: counters saturate (4-bit instance) while the 32-bit one keeps counting
    ds_valid = 1'b1; fs_allowin = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(32'h0000_8000 + 32'(i * 16), 1'b1, 1'b1, 32'h0000_9000, '0);
      step();
      clear_go();
      step();
      if (i == 14) check("sat.at15", 69'(s_mis_cnt), 69'(4'hF));
    end
    check("sat.mis_small", 69'(s_mis_cnt), 69'(4'hF));
    check("sat.br_small", 69'(s_br_cnt), 69'(4'hF));
    check_cnt("sat.big", 32'd17, 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
